// File: rtl/usart_rx.sv
// usart_rx: 8N1-style serial receiver with a first-word fall-through byte FIFO.
// The rx pin is synchronized, each frame is sampled at bit centres (start bit
// confirmed at half a bit, data and stop bits every full bit after that), and
// good bytes are queued for the host behind a valid/ready pop interface.
// Bad stop bits and bytes dropped on a full FIFO are flagged with single-cycle
// pulses.
module usart_rx #(
  parameter int CLK_FREQ    = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BIT    = 8,
  parameter int NUM_OF_BUFS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx,
  output logic [DATA_BIT-1:0]            rd_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [$clog2(NUM_OF_BUFS):0]   count,
  output logic                           frame_err,
  output logic                           overrun
);

  // Clocks per bit and clocks to the middle of the start bit.
  localparam int N_CLK  = CLK_FREQ / BAUD_RATE;
  localparam int H_CLK  = N_CLK / 2;
  // Bit-timing counter: at least 12 bits, wider for slow baud rates.
  localparam int BCNT_W = ($clog2(N_CLK) > 12) ? $clog2(N_CLK) : 12;
  localparam int IDX_W  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int PTR_W  = $clog2(NUM_OF_BUFS);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(N_CLK - 1);
  localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(H_CLK - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BIT - 1);
  localparam logic [CNT_W-1:0]  FULL_LVL  = CNT_W'(NUM_OF_BUFS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Line synchronizer
  logic rx_meta;
  logic rx_s;

  // Frame receiver
  state_t              state, state_nxt;
  logic [BCNT_W-1:0]   bit_cnt, bit_cnt_nxt;
  logic [IDX_W-1:0]    bit_idx, bit_idx_nxt;
  logic [DATA_BIT-1:0] shift, shift_nxt;
  logic                push;
  logic                fe_set;
  logic                ov_set;

  // FIFO
  logic [DATA_BIT-1:0] mem [NUM_OF_BUFS];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                pop;
  logic                full;

  assign pop  = rd_valid && rd_ready;
  assign full = (count == FULL_LVL);

  // Two-flop synchronizer for the asynchronous rx pin; idles at the line's mark level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state, bit timing and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the values from before this edge, regardless of statement order.
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state logic: sample points, push decision and error detection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push        = 1'b0;
    fe_set      = 1'b0;
    ov_set      = 1'b0;

    case (state)
      S_IDLE: begin
        bit_cnt_nxt = '0;
        if (!rx_s) begin
          state_nxt = S_START;
        end
      end

      // Re-check the line half a bit in, so short glitches are not taken as frames.
      S_START: begin
        if (bit_cnt == HALF_LAST) begin
          bit_cnt_nxt = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? S_IDLE : S_DATA;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt        = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == IDX_LAST) begin
            state_nxt = S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end

      // Returning to IDLE in the middle of the stop bit lets the next start
      // edge be caught even when frames arrive with no idle gap.
      S_STOP: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = S_IDLE;
            if (!full || pop) begin
              push = 1'b1;
            end else begin
              ov_set = 1'b1;
            end
          end else begin
            fe_set    = 1'b1;
            state_nxt = S_WAIT_HIGH;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end

      // A held-low line (break) reports one framing error, not a stream of them.
      S_WAIT_HIGH: begin
        bit_cnt_nxt = '0;
        if (rx_s) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Error pulses, registered so they are clean single-cycle strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set;
      overrun   <= ov_set;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by the pointers and count, and leaving the array unreset lets it map to RAM.
    if (push) begin
      mem[wr_ptr] <= shift;
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // First-word fall-through head; forced to zero while empty.
  always_comb begin
    rd_valid = (count != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed and randomized frames for usart_rx, checked against a
// byte-queue model of the receive FIFO. A short bit time keeps runs small.
module tb_usart_rx;

  localparam int CLK_FREQ    = 1000;
  localparam int BAUD_RATE   = 47;
  localparam int DATA_BIT    = 8;
  localparam int NUM_OF_BUFS = 16;
  localparam int N           = CLK_FREQ / BAUD_RATE;   // 21 clocks per bit
  localparam int H           = N / 2;                  // 10
  localparam int CW          = $clog2(NUM_OF_BUFS) + 1;

  logic                clk      = 1'b0;
  logic                reset    = 1'b1;
  logic                rx       = 1'b1;
  logic                rd_ready = 1'b0;
  logic [DATA_BIT-1:0] rd_data;
  logic                rd_valid;
  logic [CW-1:0]       count;
  logic                frame_err;
  logic                overrun;

  usart_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .DATA_BIT    (DATA_BIT),
    .NUM_OF_BUFS (NUM_OF_BUFS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Cycle index: cycle c is the period following the c-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Count cycles in which each error strobe is high.
  int fe_seen = 0;
  int ov_seen = 0;
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (overrun === 1'b1) ov_seen++;
  end

  int tests = 0;
  int fails = 0;
  int exp_fe = 0;
  int exp_ov = 0;

  // Reference model: the bytes the host should be able to pop, oldest first.
  logic [7:0] q[$];

  // Observations at the stop-sample cycle S and the cycle after it.
  logic          obs_valid_s, obs_fe_s, obs_valid_s1, obs_fe_s1, obs_ov_s1;
  logic [7:0]    obs_data_s, obs_data_s1;
  logic [CW-1:0] obs_count_s1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold one bit on the line for N cycles; caller is 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int s, input bit pop_at_stop);
    rx = v;
    for (int k = 0; k < N; k++) begin
      if (pop_at_stop) rd_ready = (cyc == s);
      @(negedge clk);
      if (cyc == s) begin
        obs_valid_s = rd_valid;
        obs_fe_s    = frame_err;
        obs_data_s  = rd_data;
      end
      if (cyc == s + 1) begin
        obs_valid_s1 = rd_valid;
        obs_fe_s1    = frame_err;
        obs_ov_s1    = overrun;
        obs_count_s1 = count;
        obs_data_s1  = rd_data;
      end
      @(posedge clk);
      #1;
    end
    if (pop_at_stop) rd_ready = 1'b0;
  endtask

  // Send one frame LSB first; abort_after >= 0 pulses reset after that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input bit pop_at_stop, input int abort_after);
    int s;
    // Pin falls in this cycle, rx_s is low two cycles later (E), stop sampled at E+H+9N.
    s = cyc + 2 + H + (DATA_BIT + 1) * N;
    obs_valid_s  = 1'bx;
    obs_fe_s     = 1'bx;
    obs_data_s   = 'x;
    obs_valid_s1 = 1'bx;
    obs_fe_s1    = 1'bx;
    obs_ov_s1    = 1'bx;
    obs_count_s1 = 'x;
    obs_data_s1  = 'x;
    drive_bit(1'b0, s, 1'b0);
    for (int i = 0; i < DATA_BIT; i++) begin
      drive_bit(b[i], s, 1'b0);
      if (i == abort_after) begin
        rx    = 1'b1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        return;
      end
    end
    drive_bit(stop_v, s, pop_at_stop);
  endtask

  // Good frame: update the model and compare the cycle after the stop sample.
  task automatic rx_good(input logic [7:0] b, input bit pop_at_stop, input string tag);
    logic exp_flag;
    send_frame(b, 1'b1, pop_at_stop, -1);
    if (pop_at_stop && q.size() > 0) begin
      check({tag, "_pop_head"}, obs_data_s, q[0]);
      void'(q.pop_front());
    end
    exp_flag = 1'b0;
    if (q.size() < NUM_OF_BUFS) begin
      q.push_back(b);
    end else begin
      exp_flag = 1'b1;
      exp_ov++;
    end
    check({tag, "_count"}, obs_count_s1, q.size());
    check({tag, "_overrun"}, obs_ov_s1, exp_flag);
    check({tag, "_frame_err"}, obs_fe_s1, 0);
  endtask

  // Pop the head for one cycle and compare it with the model.
  task automatic pop_one(input string tag);
    rd_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_data"}, rd_data, q[0]);
    step(1);
    rd_ready = 1'b0;
    void'(q.pop_front());
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) pop_one(tag);
    @(negedge clk);
    check({tag, "_empty_count"}, count, 0);
    check({tag, "_empty_valid"}, rd_valid, 0);
    step(1);
  endtask

  initial begin
    int fe0, ov0;
    logic [7:0] b;

    // Reset state
    step(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    step(1);

    // Pop while empty is ignored
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    @(negedge clk);
    check("empty_pop_count", count, 0);
    step(1);

    // Single byte with exact rd_valid timing
    send_frame(8'h3F, 1'b1, 1'b0, -1);
    q.push_back(8'h3F);
    check("single_valid_at_S", obs_valid_s, 0);
    check("single_valid_at_S1", obs_valid_s1, 1);
    check("single_count_at_S1", obs_count_s1, 1);
    check("single_data_at_S1", obs_data_s1, 8'h3F);
    step(N);
    rd_ready = 1'b1;
    step(1);
    rd_ready = 1'b0;
    void'(q.pop_front());
    @(negedge clk);
    check("single_pop_count", count, 0);
    check("single_pop_valid", rd_valid, 0);
    step(1);

    // Glitch held low for exactly H cycles: sampled high at E+H, rejected
    fe0 = fe_seen;
    rx = 1'b0;
    step(H);
    rx = 1'b1;
    step(2 * N);
    check("glitch_count", count, 0);
    check("glitch_frame_err", fe_seen - fe0, 0);
    rx_good(8'hA5, 1'b0, "after_glitch");
    step(N);
    drain("after_glitch");

    // Framing error followed by a break
    fe0 = fe_seen;
    send_frame(8'h55, 1'b0, 1'b0, -1);
    exp_fe++;
    check("ferr_flag_at_S", obs_fe_s, 0);
    check("ferr_flag_at_S1", obs_fe_s1, 1);
    check("ferr_count_at_S1", obs_count_s1, 0);
    step(3 * N);
    rx = 1'b1;
    step(N);
    check("ferr_pulses", fe_seen - fe0, 1);
    check("ferr_count", count, 0);
    rx_good(8'h12, 1'b0, "after_ferr");
    step(N);
    drain("after_ferr");

    // Overrun: 17 back-to-back frames into a 16-deep FIFO
    ov0 = ov_seen;
    for (int i = 0; i <= NUM_OF_BUFS; i++) begin
      b = 8'(i);
      rx_good(b, 1'b0, "overrun_fill");
    end
    step(N);
    check("overrun_pulses", ov_seen - ov0, 1);
    check("overrun_count", count, NUM_OF_BUFS);
    drain("overrun_drain");

    // Full plus pop in the stop-sample cycle: both happen, no overrun
    for (int i = 0; i < NUM_OF_BUFS; i++) begin
      b = 8'($urandom);
      rx_good(b, 1'b0, "rand_fill");
    end
    ov0 = ov_seen;
    rx_good(8'h77, 1'b1, "full_pop");
    step(N);
    check("full_pop_no_overrun", ov_seen - ov0, 0);
    check("full_pop_tail", q[NUM_OF_BUFS-1], 8'h77);
    drain("full_pop_drain");

    // Randomized mix of good frames, bad stop bits, gaps and pops
    for (int k = 0; k < 20; k++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(b, 1'b0, 1'b0, -1);
        exp_fe++;
        check("rand_ferr_flag", obs_fe_s1, 1);
        check("rand_ferr_count", obs_count_s1, q.size());
        rx = 1'b1;
        step(N);
      end else begin
        rx_good(b, ($urandom_range(0, 3) == 0), "rand_frame");
      end
      step($urandom_range(0, N));
      for (int p = $urandom_range(0, 2); p > 0 && q.size() > 0; p--) pop_one("rand_pop");
    end
    step(N);
    drain("rand_drain");

    // Reset in the middle of a frame, with bytes already queued
    rx_good(8'($urandom), 1'b0, "pre_reset");
    rx_good(8'($urandom), 1'b0, "pre_reset");
    send_frame(8'h5A, 1'b1, 1'b0, 3);
    q.delete();
    @(negedge clk);
    check("midrst_valid", rd_valid, 0);
    check("midrst_count", count, 0);
    check("midrst_data", rd_data, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    step(1);
    step(2 * N);
    rx_good(8'hC3, 1'b0, "after_reset");
    check("after_reset_data", obs_data_s1, 8'hC3);
    step(N);
    drain("after_reset");

    // Totals of error strobes over the whole run
    check("total_frame_err", fe_seen, exp_fe);
    check("total_overrun", ov_seen, exp_ov);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
